// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//   Turns one macro request into the SPI flash command sequence that implements it.
//   Codes A (sector erase) and C (page program) are preceded by WREN and followed
//   by RDSR polling until WIP clears. B (read ID), D (page read), E (read SR)
//   and F (read flag SR) issue a single command.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   macro_states[3:0]        request code (A..F accepted)
//   macro_states_valid       one-cycle request strobe
//   addr_reg[31:0]           flash byte address for the request
//   flash_macro_states_done  one-cycle completion pulse
//   busy                     operation in progress
//   timeout_err              sticky WIP-poll timeout flag
//   last_sr[7:0]             last status byte read
//   cmd_valid/cmd_ready      command handshake to the QSPI engine
//   cmd_opcode/cmd_addr/cmd_has_addr/cmd_len   command fields
//   cmd_done                 engine transaction-complete pulse
//   sr_data[7:0]             status byte, valid with cmd_done of a status read
//
// Configuration
//   FLASH_POLL_TIMEOUT_EN    when defined, POLL_MAX polls with WIP still set end
//                            the operation with timeout_err=1; otherwise polling
//                            never gives up and timeout_err is constant 0.

module flash_op_sequencer #(
  parameter logic [23:0] POLL_MAX = 24'd4_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  macro_states,
  input  logic        macro_states_valid,
  input  logic [31:0] addr_reg,
  output logic        flash_macro_states_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  last_sr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_addr,
  output logic        cmd_has_addr,
  output logic [8:0]  cmd_len,
  input  logic        cmd_done,
  input  logic [7:0]  sr_data
);

  localparam logic [3:0] CODE_A = 4'hA;
  localparam logic [3:0] CODE_B = 4'hB;
  localparam logic [3:0] CODE_C = 4'hC;
  localparam logic [3:0] CODE_D = 4'hD;
  localparam logic [3:0] CODE_E = 4'hE;
  localparam logic [3:0] CODE_F = 4'hF;

  typedef enum logic [2:0] {
    IDLE, WREN, WREN_WT, OP, OP_WT, POLL, POLL_WT, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  code_reg, code_next;
  logic [23:0] addr_lat_reg, addr_lat_next;
  logic [23:0] poll_cnt_reg, poll_cnt_next;
  logic [7:0]  last_sr_reg, last_sr_next;
  logic        timeout_next;

  // Codes A..F are exactly the upper six values of the 4-bit code space.
  logic req_ok;
  assign req_ok = macro_states_valid && (macro_states >= CODE_A);

  // Erase and program need write-enable first and WIP polling afterwards.
  logic needs_wren;
  assign needs_wren = (code_reg == CODE_A) || (code_reg == CODE_C);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  logic [23:0] poll_cnt_inc;
  assign poll_cnt_inc = (poll_cnt_reg == 24'hFF_FFFF) ? poll_cnt_reg : poll_cnt_reg + 24'd1;

`ifdef FLASH_POLL_TIMEOUT_EN
  logic timeout_err_reg;
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      code_reg        <= 4'd0;
      addr_lat_reg    <= 24'd0;
      poll_cnt_reg    <= 24'd0;
      last_sr_reg     <= 8'd0;
`ifdef FLASH_POLL_TIMEOUT_EN
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      code_reg        <= code_next;
      addr_lat_reg    <= addr_lat_next;
      poll_cnt_reg    <= poll_cnt_next;
      last_sr_reg     <= last_sr_next;
`ifdef FLASH_POLL_TIMEOUT_EN
      timeout_err_reg <= timeout_next;
`endif
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    addr_lat_next = addr_lat_reg;
    poll_cnt_next = poll_cnt_reg;
    last_sr_next  = last_sr_reg;
`ifdef FLASH_POLL_TIMEOUT_EN
    timeout_next  = timeout_err_reg;
`else
    timeout_next  = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (req_ok) begin
          code_next     = macro_states;
          addr_lat_next = addr_reg[23:0];
          poll_cnt_next = 24'd0;
          timeout_next  = 1'b0;
          state_next    = ((macro_states == CODE_A) || (macro_states == CODE_C)) ? WREN : OP;
        end
      end
      WREN:    if (cmd_ready) state_next = WREN_WT;
      WREN_WT: if (cmd_done)  state_next = OP;
      OP:      if (cmd_ready) state_next = OP_WT;
      OP_WT: begin
        if (cmd_done) begin
          if ((code_reg == CODE_E) || (code_reg == CODE_F))
            last_sr_next = sr_data;
          state_next = needs_wren ? POLL : DONE;
        end
      end
      POLL:    if (cmd_ready) state_next = POLL_WT;
      POLL_WT: begin
        if (cmd_done) begin
          last_sr_next = sr_data;
          if (!sr_data[0]) begin
            state_next = DONE;
          end else begin
            poll_cnt_next = poll_cnt_inc;
            state_next    = POLL;
`ifdef FLASH_POLL_TIMEOUT_EN
            if (poll_cnt_inc >= POLL_MAX) begin
              timeout_next = 1'b1;
              state_next   = DONE;
            end
`endif
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command fields are a pure function of state and the latched request, so
  // they cannot change while cmd_valid waits for cmd_ready.
  always_comb begin
    cmd_valid    = 1'b0;
    cmd_opcode   = 8'h00;
    cmd_addr     = 24'd0;
    cmd_has_addr = 1'b0;
    cmd_len      = 9'd0;
    case (state_reg)
      WREN: begin
        cmd_valid  = 1'b1;
        cmd_opcode = 8'h06;
      end
      OP: begin
        cmd_valid = 1'b1;
        case (code_reg)
          CODE_A: begin
            cmd_opcode   = 8'h20;
            cmd_addr     = {addr_lat_reg[23:12], 12'h000};
            cmd_has_addr = 1'b1;
          end
          CODE_B: begin
            cmd_opcode = 8'h9F;
            cmd_len    = 9'd3;
          end
          CODE_C: begin
            cmd_opcode   = 8'h02;
            cmd_addr     = {addr_lat_reg[23:8], 8'h00};
            cmd_has_addr = 1'b1;
            cmd_len      = 9'd256;
          end
          CODE_D: begin
            cmd_opcode   = 8'h03;
            cmd_addr     = addr_lat_reg;
            cmd_has_addr = 1'b1;
            cmd_len      = 9'd256;
          end
          CODE_E: begin
            cmd_opcode = 8'h05;
            cmd_len    = 9'd1;
          end
          CODE_F: begin
            cmd_opcode = 8'h70;
            cmd_len    = 9'd1;
          end
          default: cmd_valid = 1'b0;
        endcase
      end
      POLL: begin
        cmd_valid  = 1'b1;
        cmd_opcode = 8'h05;
        cmd_len    = 9'd1;
      end
      default: ;
    endcase
  end

  assign busy                    = (state_reg != IDLE);
  assign flash_macro_states_done = (state_reg == DONE);
  assign last_sr                 = last_sr_reg;

endmodule

// File: doc/flash_op_sequencer.md
FLASH_OP_SEQUENCER -- requirements
Module: flash_op_sequencer

Interface
REQ-001 SHALL have parameter: POLL_MAX, 24'd4_000_000, maximum RDSR polls before timeout.
REQ-002 SHALL have ports:
  clk  in  1  system clock
  rst_n  in  1  asynchronous active-low reset
  macro_states  in  4  macro code from the top-level sequencer
  macro_states_valid  in  1  one-cycle request strobe
  addr_reg  in  32  flash byte address for the request
  flash_macro_states_done  out  1  one-cycle completion pulse
  busy  out  1  operation in progress
  timeout_err  out  1  sticky WIP-poll timeout flag
  last_sr  out  8  last status register value read
  cmd_valid  out  1  command request to QSPI engine
  cmd_ready  in  1  engine accepts command
  cmd_opcode  out  8  flash opcode
  cmd_addr  out  24  flash address
  cmd_has_addr  out  1  command carries 3-byte address
  cmd_len  out  9  data bytes to transfer (0..256)
  cmd_done  in  1  engine transaction complete pulse
  sr_data  in  8  status byte; valid with cmd_done of an RDSR
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low on rst_n.

Function
REQ-004 SHALL accept a request only in IDLE when macro_states_valid=1 and macro_states is in {A,B,C,D,E,F}; other codes or requests while busy SHALL be ignored, with no done pulse.
REQ-005 SHALL latch macro_states and addr_reg on acceptance; busy SHALL rise the following cycle and stay high until the cycle after the done pulse.
REQ-006 SHALL use states IDLE, WREN, WREN_WT, OP, OP_WT, POLL, POLL_WT, DONE.
REQ-007 SHALL map codes: A -> WREN, then 0x20 with address, len 0; C -> WREN, then 0x02 with address, len 256; D -> 0x03 with address, len 256; B -> 0x9F, len 3; E -> 0x05, len 1; F -> 0x70, len 1.
REQ-008 SHALL force cmd_addr[11:0]=0 for A, cmd_addr[7:0]=0 for C, and pass addr_reg[23:0] unchanged for D.
REQ-009 Codes A and C SHALL enter WREN (opcode 0x06, no address, len 0); all other codes SHALL go directly to OP.
REQ-010 SHALL hold cmd_valid high with stable cmd_* fields until the cycle cmd_ready=1, and then deassert cmd_valid the next cycle (valid/ready transfer).
REQ-011 Each *_WT state SHALL wait for cmd_done; cmd_done outside a *_WT state SHALL be ignored.
REQ-012 After OP_WT completes, A and C SHALL enter POLL (opcode 0x05, len 1); other codes SHALL enter DONE.
REQ-013 On cmd_done in POLL_WT, SHALL load last_sr=sr_data; if sr_data[0]=0 SHALL go to DONE, else SHALL increment the poll counter and re-enter POLL.
REQ-014 For E and F, last_sr SHALL take sr_data on the OP_WT cmd_done.
REQ-015 DONE SHALL assert flash_macro_states_done for exactly one cycle and then return to IDLE.
REQ-016 The poll counter SHALL be 24 bits, SHALL clear on acceptance, and SHALL saturate without wrapping.
REQ-017 timeout_err SHALL clear on each acceptance.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE and drive all outputs and counters to 0, including mid-transaction.
REQ-019 After reset release, the first request SHALL be accepted no earlier than the first clk edge at which rst_n=1.

Configuration
REQ-020 With FLASH_POLL_TIMEOUT_EN defined, reaching POLL_MAX polls with WIP still 1 SHALL set timeout_err and go to DONE, so the done pulse still fires.
REQ-021 Without FLASH_POLL_TIMEOUT_EN, polling SHALL continue indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-022 Code C, addr 0x0012_34AB, sr_data WIP=1,1,0 -> commands 0x06, 0x02@0x123400 with len 256, then three 0x05 polls; one done pulse; last_sr[0]=0.
REQ-023 Code A, addr 0x0000_5FFF, WIP clear on first poll -> commands 0x06, 0x20@0x005000, 0x05; done after the poll's cmd_done +1 cycle.
REQ-024 Code E with sr_data=0x83 -> single 0x05 command; last_sr=0x83; done pulse; no WREN issued.
REQ-025 cmd_ready held low for 5 cycles -> cmd_valid and cmd_* remain stable for all 5 cycles; a second macro_states_valid while busy is ignored; exactly one done pulse.
REQ-026 FLASH_POLL_TIMEOUT_EN defined, POLL_MAX=4, WIP stuck at 1 -> 4 polls, timeout_err=1, done pulse; rst_n low mid-POLL -> immediate IDLE with all outputs 0.
